// File: rtl/if_id_queue_if.sv
// Fetch-to-decode handshake bundle for the IF/ID instruction queue.
// The queue takes the slave view; the surrounding pipeline takes the master view.
interface if_id_queue_if #(
  parameter int WIDTH = 32
);
  logic             InValid;
  logic [WIDTH-1:0] Instruction;
  logic [WIDTH-1:0] PCResult;
  logic             InReady;
  logic             Flush;
  logic             OutValid;
  logic             OutReady;
  logic [WIDTH-1:0] OutInstruction;
  logic [WIDTH-1:0] OutPC;
  logic [1:0]       Count;

  modport slave (
    input  InValid, Instruction, PCResult, Flush, OutReady,
    output InReady, OutValid, OutInstruction, OutPC, Count
  );

  modport master (
    output InValid, Instruction, PCResult, Flush, OutReady,
    input  InReady, OutValid, OutInstruction, OutPC, Count
  );
endinterface

// File: rtl/if_id_queue.sv
// Two-entry {instruction, PC} FIFO between fetch and decode.
// The handshake outputs decode registered occupancy only, so there is no combinational path from input to output.
module if_id_queue #(
  parameter int WIDTH = 32
) (
  input logic          Clk,
  input logic          Reset,
  if_id_queue_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  occ_e             occ;
  occ_e             occ_next;
  logic             rd_ptr;
  logic             wr_ptr;
  logic [WIDTH-1:0] instr_mem [2];
  logic [WIDTH-1:0] pc_mem    [2];

  logic in_ready;
  logic out_valid;
  logic push;
  logic pop;

  assign in_ready  = (occ != FULL);
  assign out_valid = (occ != EMPTY);
  assign push      = bus.InValid  && in_ready;
  assign pop       = bus.OutReady && out_valid;

  assign bus.InReady        = in_ready;
  assign bus.OutValid       = out_valid;
  assign bus.OutInstruction = out_valid ? instr_mem[rd_ptr] : '0;
  assign bus.OutPC          = out_valid ? pc_mem[rd_ptr]    : '0;
  assign bus.Count          = occ;

  // NOTE: occ_next is given a default before the case so every path assigns it and no latch is inferred.
  always_comb begin
    occ_next = occ;
    unique case ({push, pop})
      2'b10:   occ_next = (occ == EMPTY) ? ONE : FULL;
      2'b01:   occ_next = (occ == FULL)  ? ONE : EMPTY;
      default: occ_next = occ;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      occ    <= EMPTY;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      // NOTE: the slots are reset because there are only two of them and a known NOP/PC 0 is wanted after reset.
      for (int i = 0; i < 2; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else if (bus.Flush) begin
      // A branch redirect drops everything queued and any push offered this cycle; the data words are left as they are.
      occ    <= EMPTY;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) begin
        instr_mem[wr_ptr] <= bus.Instruction;
        pc_mem[wr_ptr]    <= bus.PCResult;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      occ <= occ_next;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed vector bench for if_id_queue: a table of per-edge stimulus and expected outputs,
// plus a hand-written sequence for an asynchronous reset taken in the middle of a clock cycle.
module tb_if_id_queue;

  logic Clk;
  logic Reset;

  if_id_queue_if #(.WIDTH(32)) bus ();

  if_id_queue #(.WIDTH(32)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        in_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        out_ready;
    logic        flush;
    logic [1:0]  count;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
  } vec_t;

  vec_t vecs[$];
  int   tests  = 0;
  int   failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [1:0] cnt, input logic ir,
                               input logic ov, input logic [31:0] oi, input logic [31:0] opc);
    check({tag, ".Count"},          {30'd0, bus.Count},   {30'd0, cnt});
    check({tag, ".InReady"},        {31'd0, bus.InReady}, {31'd0, ir});
    check({tag, ".OutValid"},       {31'd0, bus.OutValid}, {31'd0, ov});
    check({tag, ".OutInstruction"}, bus.OutInstruction,   oi);
    check({tag, ".OutPC"},          bus.OutPC,            opc);
  endtask

  function automatic vec_t mk(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                              input logic ordy, input logic fl, input logic [1:0] cnt,
                              input logic ir, input logic ov, input logic [31:0] oi,
                              input logic [31:0] opc);
    vec_t v;
    v.in_valid  = iv;
    v.instr     = ins;
    v.pc        = pc;
    v.out_ready = ordy;
    v.flush     = fl;
    v.count     = cnt;
    v.in_ready  = ir;
    v.out_valid = ov;
    v.out_instr = oi;
    v.out_pc    = opc;
    return v;
  endfunction

  task automatic drive(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    bus.InValid     = iv;
    bus.Instruction = ins;
    bus.PCResult    = pc;
    bus.OutReady    = ordy;
    bus.Flush       = fl;
  endtask

  initial begin
    //              iv  instr          pc     ordy fl  | cnt ir ov  out_instr      out_pc
    // first push after reset, then PC 0x8 offered into a full queue
    vecs.push_back(mk(1, 32'h2008_0005, 32'h00, 0, 0,   2'd1, 1, 1, 32'h2008_0005, 32'h00));
    vecs.push_back(mk(1, 32'hA000_0004, 32'h04, 0, 0,   2'd2, 0, 1, 32'h2008_0005, 32'h00));
    vecs.push_back(mk(1, 32'hA000_0008, 32'h08, 0, 0,   2'd2, 0, 1, 32'h2008_0005, 32'h00));
    // drain from FULL while fetch keeps offering PC 0x8: order 0x0, 0x4, 0x8 across the wrap
    vecs.push_back(mk(1, 32'hA000_0008, 32'h08, 1, 0,   2'd1, 1, 1, 32'hA000_0004, 32'h04));
    vecs.push_back(mk(1, 32'hA000_0008, 32'h08, 1, 0,   2'd1, 1, 1, 32'hA000_0008, 32'h08));
    vecs.push_back(mk(0, 32'h0,         32'h00, 1, 0,   2'd0, 1, 0, 32'h0,         32'h00));
    // pop request while EMPTY is ignored
    vecs.push_back(mk(0, 32'h0,         32'h00, 1, 0,   2'd0, 1, 0, 32'h0,         32'h00));
    // ONE with simultaneous push and pop: new entry becomes head
    vecs.push_back(mk(1, 32'hA000_0010, 32'h10, 0, 0,   2'd1, 1, 1, 32'hA000_0010, 32'h10));
    vecs.push_back(mk(1, 32'hA000_0014, 32'h14, 1, 0,   2'd1, 1, 1, 32'hA000_0014, 32'h14));
    vecs.push_back(mk(0, 32'h0,         32'h00, 1, 0,   2'd0, 1, 0, 32'h0,         32'h00));
    // EMPTY with push and pop: only the push happens
    vecs.push_back(mk(1, 32'hA000_0018, 32'h18, 1, 0,   2'd1, 1, 1, 32'hA000_0018, 32'h18));
    vecs.push_back(mk(1, 32'hA000_001C, 32'h1C, 0, 0,   2'd2, 0, 1, 32'hA000_0018, 32'h18));
    // Flush in FULL with a push offered: PC 0x20 is dropped
    vecs.push_back(mk(1, 32'hA000_0020, 32'h20, 0, 1,   2'd0, 1, 0, 32'h0,         32'h00));
    vecs.push_back(mk(1, 32'hA000_0024, 32'h24, 0, 0,   2'd1, 1, 1, 32'hA000_0024, 32'h24));
    vecs.push_back(mk(1, 32'hA000_0028, 32'h28, 0, 0,   2'd2, 0, 1, 32'hA000_0024, 32'h24));
    // Flush overrides a simultaneous pop too
    vecs.push_back(mk(1, 32'hA000_002C, 32'h2C, 1, 1,   2'd0, 1, 0, 32'h0,         32'h00));
    vecs.push_back(mk(1, 32'hA000_0030, 32'h30, 1, 0,   2'd1, 1, 1, 32'hA000_0030, 32'h30));
    vecs.push_back(mk(1, 32'hA000_0034, 32'h34, 1, 0,   2'd1, 1, 1, 32'hA000_0034, 32'h34));
    vecs.push_back(mk(0, 32'h0,         32'h00, 1, 0,   2'd0, 1, 0, 32'h0,         32'h00));

    Reset = 1'b0;
    drive(0, 32'h0, 32'h0, 0, 0);
    #1;
    check_outputs("reset", 2'd0, 1'b1, 1'b0, 32'h0, 32'h0);

    @(negedge Clk);
    Reset = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].in_valid, vecs[i].instr, vecs[i].pc, vecs[i].out_ready, vecs[i].flush);
      @(posedge Clk);
      #1;
      check_outputs($sformatf("vec%0d", i), vecs[i].count, vecs[i].in_ready,
                    vecs[i].out_valid, vecs[i].out_instr, vecs[i].out_pc);
    end

    // Fill the queue, then assert reset between edges and look before the next edge.
    drive(1, 32'hA000_0040, 32'h40, 0, 0);
    @(posedge Clk);
    #1;
    drive(1, 32'hA000_0044, 32'h44, 0, 0);
    @(posedge Clk);
    #1;
    check_outputs("full_before_reset", 2'd2, 1'b0, 1'b1, 32'hA000_0040, 32'h40);
    #3;
    Reset = 1'b0;
    #1;
    check_outputs("async_reset", 2'd0, 1'b1, 1'b0, 32'h0, 32'h0);

    // Release reset mid-cycle; the very next edge must take the push.
    #2;
    Reset = 1'b1;
    drive(1, 32'hA000_0048, 32'h48, 0, 0);
    @(posedge Clk);
    #1;
    check_outputs("first_push_after_reset", 2'd1, 1'b1, 1'b1, 32'hA000_0048, 32'h48);

    drive(0, 32'h0, 32'h0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
